// File: rtl/ram_access_ctrl_if.sv
// Host-side request/response channels of ram_access_ctrl.
// The host drives the master modport and the controller uses the slave modport.
interface ram_access_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sole driver of a single-port synchronous RAM (1-cycle read latency); serves host reads/writes.
// Define RAM_ACCESS_CTRL_BIST_EN to compile in the pattern self-test.
module ram_access_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_access_ctrl_if.slave host,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout,
    input  logic             bist_start,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_fail,
    output logic [AW-1:0]    bist_fail_addr
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        RSP
`ifdef RAM_ACCESS_CTRL_BIST_EN
        ,
        BIST_WR,
        BIST_RD,
        BIST_CAP
`endif
    } state_e;

    state_e        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;

`ifdef RAM_ACCESS_CTRL_BIST_EN
    logic          ph_q, ph_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [AW-1:0] addr_nxt;

    // Pattern alternates 01 pairs so adjacent bits differ, then folds in the address.
    function automatic logic [DW-1:0] bist_pattern(input logic [AW-1:0] a);
        logic [DW-1:0] base;
        base = {(DW/2){2'b01}};
        return base ^ DW'(a);
    endfunction

    assign addr_nxt = ram_addr_q + AW'(1);
`else
    logic bist_start_unused;
    assign bist_start_unused = bist_start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
`ifdef RAM_ACCESS_CTRL_BIST_EN
            ph_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
`ifdef RAM_ACCESS_CTRL_BIST_EN
            ph_q        <= ph_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
`ifdef RAM_ACCESS_CTRL_BIST_EN
        ph_d        = ph_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef RAM_ACCESS_CTRL_BIST_EN
                if (bist_start) begin
                    state_d     = BIST_WR;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    ph_d        = 1'b0;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = '0;
                    ram_din_d   = bist_pattern('0);
                end else
`endif
                if (host.req_valid) begin
                    req_ready_d = 1'b0;
                    ram_addr_d  = host.req_addr;
                    if (host.req_write) begin
                        state_d   = WR;
                        ram_we_d  = 1'b1;
                        ram_din_d = host.req_wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                ram_we_d    = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            // Address is on the pins this cycle; data appears next cycle.
            RD: state_d = CAP;
            CAP: begin
                rsp_rdata_d = ram_dout;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (host.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef RAM_ACCESS_CTRL_BIST_EN
            // Phase 0 drives the write strobe, phase 1 is the idle half of the 2-cycle slot.
            BIST_WR: begin
                if (!ph_q) begin
                    ram_we_d = 1'b0;
                    ph_d     = 1'b1;
                end else if (ram_addr_q == '1) begin
                    state_d    = BIST_RD;
                    ram_addr_d = '0;
                    ph_d       = 1'b0;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_nxt;
                    ram_din_d  = bist_pattern(addr_nxt);
                    ph_d       = 1'b0;
                end
            end
            BIST_RD: state_d = BIST_CAP;
            BIST_CAP: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                    if ((ram_dout != bist_pattern(ram_addr_q)) && !fail_q) begin
                        fail_d      = 1'b1;
                        fail_addr_d = ram_addr_q;
                    end
                end else begin
                    ph_d = 1'b0;
                    if (ram_addr_q == '1) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        req_ready_d = 1'b1;
                    end else begin
                        state_d    = BIST_RD;
                        ram_addr_d = addr_nxt;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign host.req_ready = req_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_din        = ram_din_q;

`ifdef RAM_ACCESS_CTRL_BIST_EN
    assign bist_busy      = busy_q;
    assign bist_done      = done_q;
    assign bist_fail      = fail_q;
    assign bist_fail_addr = fail_addr_q;
`else
    assign bist_busy      = 1'b0;
    assign bist_done      = 1'b0;
    assign bist_fail      = 1'b0;
    assign bist_fail_addr = '0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 16x8 synchronous RAM model.
// Self-test scenarios are exercised when RAM_ACCESS_CTRL_BIST_EN is defined.
module tb_ram_access_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic bist_start = 1'b0;
    logic bist_busy, bist_done, bist_fail;
    logic [3:0] bist_fail_addr;
    logic ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'h00;
    logic [7:0] mem [16] = '{default: 8'h00};
    logic stuck_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;

    ram_access_ctrl_if #(.AW(4), .DW(8)) bus ();

    ram_access_ctrl #(.AW(4), .DW(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host           (bus),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model; the injected fault forces bit 0 high at address 7 on readback.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= (stuck_en && ram_addr == 4'h7) ? (mem[ram_addr] | 8'h01) : mem[ram_addr];
    end

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    wire [29:0] outs = {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, ram_we, ram_addr, ram_din,
                        bist_busy, bist_done, bist_fail, bist_fail_addr};
    localparam logic [29:0] RST_OUTS = 30'h2000_0000;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (outs !== RST_OUTS) begin
            errors++;
            $display("FAIL reset_values got=%h want=%h", outs, RST_OUTS);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b want=1", bus.req_ready);
        end
    endtask

    task automatic test_write_read();
        logic [3:0] ad [2];
        logic [7:0] dt [2];
        int w0;
        ad[0] = 4'h1; dt[0] = 8'hA5;
        ad[1] = 4'h2; dt[1] = 8'h5A;
        w0 = we_cnt;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, ad[i], dt[i]);
            checks++;
            if ({ram_we, ram_addr, ram_din, bus.req_ready} !== {1'b1, ad[i], dt[i], 1'b0}) begin
                errors++;
                $display("FAIL write_pins[%0d] got=%h want=%h", i,
                         {ram_we, ram_addr, ram_din, bus.req_ready}, {1'b1, ad[i], dt[i], 1'b0});
            end
            step();
            checks++;
            if ({ram_we, bus.req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL write_end[%0d] got=%b want=01", i, {ram_we, bus.req_ready});
            end
        end
        checks++;
        if (we_cnt - w0 !== 2) begin
            errors++;
            $display("FAIL write_strobe_cycles got=%0d want=2", we_cnt - w0);
        end
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, ad[i], 8'h00);
            checks++;
            if ({ram_we, ram_addr, bus.rsp_valid} !== {1'b0, ad[i], 1'b0}) begin
                errors++;
                $display("FAIL read_addr[%0d] got=%h want=%h", i,
                         {ram_we, ram_addr, bus.rsp_valid}, {1'b0, ad[i], 1'b0});
            end
            step();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL read_early_valid[%0d] got=%b want=0", i, bus.rsp_valid);
            end
            step();
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, dt[i]}) begin
                errors++;
                $display("FAIL read_data[%0d] got=%h want=%h", i,
                         {bus.rsp_valid, bus.rsp_rdata}, {1'b1, dt[i]});
            end
            step();
            checks++;
            if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL read_release[%0d] got=%b want=01", i, {bus.rsp_valid, bus.req_ready});
            end
        end
    endtask

    task automatic test_rsp_backpressure();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'h1, 8'h00);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready} !== {1'b1, 8'hA5, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got=%h want=%h", k,
                         {bus.rsp_valid, bus.rsp_rdata, bus.req_ready}, {1'b1, 8'hA5, 1'b0});
            end
            if (k < 4) step();
        end
        bus.rsp_ready = 1'b1;
        step();
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release got=%b want=01", {bus.rsp_valid, bus.req_ready});
        end
    endtask

    task automatic test_held_valid();
        int w0;
        w0 = we_cnt;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 4'h3;
        bus.req_wdata = 8'h3C;
        step();
        checks++;
        if ({ram_we, bus.req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL held_wr_busy got=%b want=10", {ram_we, bus.req_ready});
        end
        step();
        checks++;
        if ({ram_we, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL held_wr_end got=%b want=01", {ram_we, bus.req_ready});
        end
        bus.req_write = 1'b0;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL held_readback got=%h want=%h", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 8'h3C});
        end
        checks++;
        if (we_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL held_single_write got=%0d want=1", we_cnt - w0);
        end
        step();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL held_ready_return got=%b want=1", bus.req_ready);
        end
    endtask

    task automatic test_async_reset();
        int r0;
        r0 = rsp_cnt;
        bus.rsp_ready = 1'b1;
        issue(1'b0, 4'h2, 8'h00);
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== RST_OUTS) begin
            errors++;
            $display("FAIL async_reset_cap got=%h want=%h", outs, RST_OUTS);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL async_reset_after got=%b want=10", {bus.req_ready, bus.rsp_valid});
        end
        step();
        step();
        checks++;
        if (rsp_cnt !== r0) begin
            errors++;
            $display("FAIL async_reset_no_rsp got=%0d want=%0d", rsp_cnt, r0);
        end
        issue(1'b1, 4'hF, 8'h11);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL async_reset_we got=%b want=01", {ram_we, bus.req_ready});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef RAM_ACCESS_CTRL_BIST_EN
    task automatic bist_run(output int done_at, output bit blk_bad);
        done_at = 0;
        blk_bad = 1'b0;
        bus.rsp_ready = 1'b1;
        bist_start    = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'h1;
        step();
        bist_start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (bist_done) begin
                done_at = k;
                break;
            end
            if (!bist_busy || bus.req_ready || bus.rsp_valid) blk_bad = 1'b1;
            step();
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_bist_clean();
        int done_at;
        bit blk_bad;
        logic [3:0] ad [2];
        logic [7:0] dt [2];
        ad[0] = 4'h7; dt[0] = 8'h52;
        ad[1] = 4'hC; dt[1] = 8'h59;
        bist_run(done_at, blk_bad);
        checks++;
        if (done_at !== 81) begin
            errors++;
            $display("FAIL bist_clean_cycles got=%0d want=81", done_at);
        end
        checks++;
        if (blk_bad !== 1'b0) begin
            errors++;
            $display("FAIL bist_clean_blocking got=%b want=0", blk_bad);
        end
        checks++;
        if ({bist_busy, bist_fail, bist_fail_addr, bus.req_ready} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL bist_clean_status got=%h want=%h",
                     {bist_busy, bist_fail, bist_fail_addr, bus.req_ready}, {1'b0, 1'b0, 4'h0, 1'b1});
        end
        step();
        checks++;
        if (bist_done !== 1'b0) begin
            errors++;
            $display("FAIL bist_done_pulse got=%b want=0", bist_done);
        end
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, ad[i], 8'h00);
            step();
            step();
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, dt[i]}) begin
                errors++;
                $display("FAIL bist_pattern[%0d] got=%h want=%h", i,
                         {bus.rsp_valid, bus.rsp_rdata}, {1'b1, dt[i]});
            end
            step();
        end
    endtask

    task automatic test_bist_stuck();
        int done_at;
        bit blk_bad;
        stuck_en = 1'b1;
        bist_run(done_at, blk_bad);
        stuck_en = 1'b0;
        checks++;
        if ({done_at == 81, blk_bad} !== 2'b10) begin
            errors++;
            $display("FAIL bist_stuck_run got=cycles %0d blk %b want=cycles 81 blk 0", done_at, blk_bad);
        end
        checks++;
        if ({bist_fail, bist_fail_addr} !== {1'b1, 4'h7}) begin
            errors++;
            $display("FAIL bist_stuck_flag got=%h want=%h", {bist_fail, bist_fail_addr}, {1'b1, 4'h7});
        end
        step();
        checks++;
        if ({bist_fail, bist_fail_addr} !== {1'b1, 4'h7}) begin
            errors++;
            $display("FAIL bist_stuck_sticky got=%h want=%h", {bist_fail, bist_fail_addr}, {1'b1, 4'h7});
        end
    endtask

    task automatic test_bist_rerun();
        int done_at;
        bit blk_bad;
        bist_run(done_at, blk_bad);
        checks++;
        if ({done_at == 81, bist_fail, bist_fail_addr} !== {1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL bist_rerun_clear got=cycles %0d fail %b addr %h want=cycles 81 fail 0 addr 0",
                     done_at, bist_fail, bist_fail_addr);
        end
        step();
    endtask
`else
    task automatic test_bist_absent();
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bist_busy, bist_done, bist_fail, bist_fail_addr, bus.req_ready, ram_we} !== 9'b000000010) begin
                errors++;
                $display("FAIL bist_absent[%0d] got=%b want=000000010", k,
                         {bist_busy, bist_done, bist_fail, bist_fail_addr, bus.req_ready, ram_we});
            end
            step();
        end
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_rsp_backpressure();
        test_held_valid();
        test_async_reset();
`ifdef RAM_ACCESS_CTRL_BIST_EN
        test_bist_clean();
        test_bist_stuck();
        test_bist_rerun();
`else
        test_bist_absent();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
